// File: rtl/paper_float_to_log_drain.sv
// Two-stage float-to-log (Mitchell) converter with valid/ready handshake and sticky saturation flags.
// Optional macro PAPER_FLOAT_TO_LOG_RNE_EN selects round-to-nearest-even fraction reduction (default: truncate).
module paper_float_to_log_drain #(
  parameter int EXP      = 8,
  parameter int FRAC     = 7,
  parameter int ACC_EXP  = 8,
  parameter int ACC_FRAC = 7
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ACC_EXP+ACC_FRAC:0]   accIn,
  input  logic                        accInValid,
  output logic                        accInReady,
  output logic [EXP+FRAC:0]           logOut,
  output logic                        logOutValid,
  input  logic                        logOutReady,
  output logic                        overflowSticky,
  output logic                        underflowSticky
);

  localparam int ACC_BIAS = (1 << (ACC_EXP - 1)) - 1;
  localparam int BIAS     = (1 << (EXP - 1)) - 1;
  localparam int LOG_MAX  = (1 << EXP) - 1;

  logic                        inSign;
  logic [ACC_EXP-1:0]          inExp;
  logic [ACC_FRAC-1:0]         inFrac;
  logic                        inZero;
  logic                        inInf;
  logic [FRAC-1:0]             roundFrac;
  logic                        roundCarry;
  logic signed [ACC_EXP+1:0]   expNext;

  logic                        s1Valid;
  logic                        s1Sign;
  logic                        s1Zero;
  logic                        s1Inf;
  logic signed [ACC_EXP+1:0]   s1Exp;
  logic [FRAC-1:0]             s1Frac;

  logic                        s2Valid;
  logic [EXP+FRAC:0]           s2Data;

  logic                        s1Advance;
  logic                        s2Advance;
  logic signed [31:0]          expWide;
  logic [EXP+FRAC:0]           packNext;
  logic                        ovfNext;
  logic                        unfNext;

  assign inSign = accIn[ACC_EXP+ACC_FRAC];
  assign inExp  = accIn[ACC_EXP+ACC_FRAC-1:ACC_FRAC];
  assign inFrac = accIn[ACC_FRAC-1:0];
  assign inZero = (inExp == '0);
  assign inInf  = (inExp == '1);

  // Reduce the accumulator fraction to FRAC bits; a rounding carry bumps the exponent.
  generate
    if (ACC_FRAC == FRAC) begin : g_exact
      assign roundFrac  = inFrac;
      assign roundCarry = 1'b0;
    end else begin : g_reduce
      localparam int DROP = ACC_FRAC - FRAC;
      logic [FRAC-1:0] kept;
      assign kept = inFrac[ACC_FRAC-1:DROP];
`ifdef PAPER_FLOAT_TO_LOG_RNE_EN
      logic          guardBit;
      logic          stickyBit;
      logic          roundUp;
      logic [FRAC:0] sum;
      assign guardBit = inFrac[DROP-1];
      if (DROP > 1) begin : g_sticky
        assign stickyBit = |inFrac[DROP-2:0];
      end else begin : g_nosticky
        assign stickyBit = 1'b0;
      end
      assign roundUp    = guardBit & (stickyBit | kept[0]);
      assign sum        = {1'b0, kept} + {{FRAC{1'b0}}, roundUp};
      assign roundFrac  = sum[FRAC-1:0];
      assign roundCarry = sum[FRAC];
`else
      logic unusedDropped;
      assign unusedDropped = ^inFrac[DROP-1:0];
      assign roundFrac  = kept;
      assign roundCarry = 1'b0;
`endif
    end
  endgenerate

  assign expNext = $signed({2'b00, inExp}) - (ACC_EXP+2)'(ACC_BIAS) + (ACC_EXP+2)'(BIAS)
                 + $signed({{(ACC_EXP+1){1'b0}}, roundCarry});

  assign s2Advance   = !s2Valid || logOutReady;
  assign s1Advance   = !s1Valid || s2Advance;
  assign accInReady  = s1Advance;
  assign logOutValid = s2Valid;
  assign logOut      = s2Data;
  assign expWide     = 32'(s1Exp);

  // Pack the S1 result into log format, saturating out-of-range exponents.
  always_comb begin
    packNext = '0;
    ovfNext  = 1'b0;
    unfNext  = 1'b0;
    if (s1Zero) begin
      packNext = '0;
    end else if (s1Inf) begin
      packNext = {s1Sign, {EXP{1'b1}}, {FRAC{1'b0}}};
    end else if (expWide >= LOG_MAX) begin
      packNext = {s1Sign, {EXP{1'b1}}, {FRAC{1'b0}}};
      ovfNext  = 1'b1;
    end else if (expWide <= 0) begin
      unfNext  = 1'b1;
    end else begin
      packNext = {s1Sign, expWide[EXP-1:0], s1Frac};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Sign  <= 1'b0;
      s1Zero  <= 1'b0;
      s1Inf   <= 1'b0;
      s1Exp   <= '0;
      s1Frac  <= '0;
    end else if (s1Advance) begin
      s1Valid <= accInValid;
      if (accInValid) begin
        s1Sign <= inSign;
        s1Zero <= inZero;
        s1Inf  <= inInf;
        s1Exp  <= expNext;
        s1Frac <= roundFrac;
      end
    end
  end

  // Flags latch when the offending result is loaded into S2.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2Valid         <= 1'b0;
      s2Data          <= '0;
      overflowSticky  <= 1'b0;
      underflowSticky <= 1'b0;
    end else if (s2Advance) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Data          <= packNext;
        overflowSticky  <= overflowSticky | ovfNext;
        underflowSticky <= underflowSticky | unfNext;
      end
    end
  end

endmodule

// File: tb/tb_paper_float_to_log_drain.sv
// Directed bench for paper_float_to_log_drain (EXP=5, FRAC=4, ACC_EXP=8, ACC_FRAC=7).
module tb_paper_float_to_log_drain;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] accIn;
  logic        accInValid;
  logic        accInReady;
  logic [9:0]  logOut;
  logic        logOutValid;
  logic        logOutReady;
  logic        overflowSticky;
  logic        underflowSticky;

  int testCount = 0;
  int failCount = 0;

  paper_float_to_log_drain #(.EXP(5), .FRAC(4), .ACC_EXP(8), .ACC_FRAC(7)) dut (
    .clock(clock),
    .reset(reset),
    .accIn(accIn),
    .accInValid(accInValid),
    .accInReady(accInReady),
    .logOut(logOut),
    .logOutValid(logOutValid),
    .logOutReady(logOutReady),
    .overflowSticky(overflowSticky),
    .underflowSticky(underflowSticky)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One transfer with ready high; result must appear exactly two edges later.
  task automatic applyStimulus(input string tag, input logic [15:0] value, input logic [9:0] expected);
    accIn       = value;
    accInValid  = 1'b1;
    logOutReady = 1'b1;
    #1;
    checkOutput({tag, " ready"}, 32'(accInReady), 32'd1);
    @(posedge clock); #1;
    accInValid = 1'b0;
    accIn      = '0;
    checkOutput({tag, " early"}, 32'(logOutValid), 32'd0);
    @(posedge clock); #1;
    checkOutput({tag, " valid"}, 32'(logOutValid), 32'd1);
    checkOutput(tag, 32'(logOut), 32'(expected));
  endtask

  logic [15:0] streamIn  [6] = '{16'h3F80, 16'h3F90, 16'h3FA0, 16'h4000, 16'h4010, 16'h3E80};
  logic [9:0]  streamExp [6] = '{10'h0F0, 10'h0F2, 10'h0F4, 10'h100, 10'h102, 10'h0D0};
  logic [9:0]  tieExp;
  logic [9:0]  carryExp;

  initial begin
    int idx;
    int outIdx;
    logic accTake;
    logic outTake;

`ifdef PAPER_FLOAT_TO_LOG_RNE_EN
    tieExp   = 10'h0F2;
    carryExp = 10'h100;
`else
    tieExp   = 10'h0F1;
    carryExp = 10'h0FF;
`endif

    reset       = 1'b1;
    accIn       = '0;
    accInValid  = 1'b0;
    logOutReady = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset valid", 32'(logOutValid), 32'd0);
    checkOutput("reset logOut", 32'(logOut), 32'd0);
    checkOutput("reset ovf", 32'(overflowSticky), 32'd0);
    checkOutput("reset unf", 32'(underflowSticky), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("ready after reset", 32'(accInReady), 32'd1);

    applyStimulus("one", 16'h3F80, 10'h0F0);
    applyStimulus("tie", 16'h3F8C, tieExp);
    applyStimulus("carry", 16'h3FFF, carryExp);
    applyStimulus("zero", 16'h0000, 10'h000);
    applyStimulus("neg denorm", 16'h8055, 10'h000);
    applyStimulus("pos inf", 16'h7F80, 10'h1F0);
    applyStimulus("neg inf", 16'hFF80, 10'h3F0);
    applyStimulus("neg one", 16'hBF80, 10'h2F0);
    applyStimulus("two", 16'h4000, 10'h100);
    applyStimulus("frac", 16'h4120, 10'h124);
    checkOutput("no ovf yet", 32'(overflowSticky), 32'd0);
    checkOutput("no unf yet", 32'(underflowSticky), 32'd0);

    applyStimulus("overflow", 16'h4780, 10'h1F0);
    checkOutput("ovf set", 32'(overflowSticky), 32'd1);
    checkOutput("unf clear", 32'(underflowSticky), 32'd0);
    applyStimulus("neg overflow", 16'hC780, 10'h3F0);

    // Back-to-back normals: one result per cycle, overflow flag must stay set.
    for (int c = 0; c <= 10; c++) begin
      accInValid = (c < 10);
      accIn      = (c < 10) ? {1'b0, 8'(120 + c), 4'(c), 3'b000} : 16'h0000;
      @(posedge clock); #1;
      if (c >= 1) begin
        checkOutput("burst valid", 32'(logOutValid), 32'd1);
        checkOutput("burst data", 32'(logOut), 32'({1'b0, 5'(c - 1 + 8), 4'(c - 1)}));
        checkOutput("ovf sticky", 32'(overflowSticky), 32'd1);
      end
    end
    accInValid = 1'b0;

    applyStimulus("underflow", 16'h3800, 10'h000);
    checkOutput("unf set", 32'(underflowSticky), 32'd1);
    checkOutput("ovf still set", 32'(overflowSticky), 32'd1);
    @(posedge clock); #1;

    // Stall the consumer for five cycles while offering six items.
    idx    = 0;
    outIdx = 0;
    for (int c = 0; c < 40 && outIdx < 6; c++) begin
      logOutReady = (c >= 5);
      accInValid  = (idx < 6);
      accIn       = (idx < 6) ? streamIn[idx] : 16'h0000;
      #1;
      accTake = accInValid && accInReady;
      outTake = logOutValid && logOutReady;
      if (outTake) begin
        checkOutput("stream order", 32'(logOut), 32'(streamExp[outIdx]));
        outIdx++;
      end else if (logOutValid && c < 5) begin
        checkOutput("stall hold", 32'(logOut), 32'(streamExp[0]));
      end
      @(posedge clock);
      if (accTake) idx++;
      #1;
      if (c == 4) begin
        checkOutput("accepted while stalled", 32'(idx), 32'd2);
        checkOutput("ready low while stalled", 32'(accInReady), 32'd0);
      end
    end
    checkOutput("stream count", 32'(outIdx), 32'd6);
    accInValid  = 1'b0;
    logOutReady = 1'b1;
    @(posedge clock); #1;

    // Fill both stages with flags set, then reset mid-flight.
    logOutReady = 1'b0;
    accInValid  = 1'b1;
    accIn       = 16'h3F80;
    @(posedge clock); #1;
    accIn = 16'h4000;
    @(posedge clock); #1;
    accInValid = 1'b0;
    checkOutput("full valid", 32'(logOutValid), 32'd1);
    checkOutput("full not ready", 32'(accInReady), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("flush valid", 32'(logOutValid), 32'd0);
    checkOutput("flush logOut", 32'(logOut), 32'd0);
    checkOutput("flush ovf", 32'(overflowSticky), 32'd0);
    checkOutput("flush unf", 32'(underflowSticky), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("ready after flush", 32'(accInReady), 32'd1);
    checkOutput("no stale output", 32'(logOutValid), 32'd0);
    applyStimulus("post reset", 16'h3F80, 10'h0F0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/paper_float_to_log_drain.md
PAPER_FLOAT_TO_LOG_DRAIN -- requirements
Module: paper_float_to_log_drain

Interface
REQ-001 SHALL have parameter EXP, default 8: output log integer (exponent) field width.
REQ-002 SHALL have parameter FRAC, default 7: output log fraction field width; FRAC <= ACC_FRAC is required.
REQ-003 SHALL have parameter ACC_EXP, default 8: input float exponent width, bias 2^(ACC_EXP-1)-1.
REQ-004 SHALL have parameter ACC_FRAC, default 7: input float fraction width.
REQ-005 SHALL have port clock  input  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port accIn  input  1+ACC_EXP+ACC_FRAC: packed {sign, biased exp, frac} accumulator float.
REQ-008 SHALL have port accInValid  input  1: accIn holds a result.
REQ-009 SHALL have port accInReady  output  1: block accepts accIn this cycle.
REQ-010 SHALL have port logOut  output  1+EXP+FRAC: packed {sign, biased log exp (bias 2^(EXP-1)-1), log frac}.
REQ-011 SHALL have port logOutValid  output  1: logOut holds a result.
REQ-012 SHALL have port logOutReady  input  1: consumer accepts logOut this cycle.
REQ-013 SHALL have port overflowSticky  output  1; and port underflowSticky  output  1: sticky saturation flags.

Function
REQ-014 Transfer SHALL occur on a cycle where valid and ready are both high, per port.
REQ-015 Two pipeline stages (S1 decode/round, S2 pack/saturate); latency SHALL be exactly 2 cycles from input transfer to logOutValid with no back-pressure.
REQ-016 Throughput SHALL be one result per cycle with logOutReady held high.
REQ-017 S2 SHALL advance when S2 is empty or logOutReady=1; S1 SHALL advance when S1 is empty or S2 advances; accInReady SHALL equal (S1 empty or S1 advances), combinational and independent of accInValid.
REQ-018 While logOutValid=1 and logOutReady=0, logOut SHALL hold stable; no result SHALL be dropped, duplicated or reordered.
REQ-019 Input decode: exp==0 means zero (fraction ignored, denormals flushed); exp==all-ones means infinity.
REQ-020 Finite conversion (Mitchell): log frac = accIn frac reduced to FRAC bits per REQ-027; log exp = accExp - ACC_BIAS + BIAS + rounding carry, computed in a signed width of ACC_EXP+2 bits.
REQ-021 Rounding carry out of the fraction SHALL zero the fraction and increment the exponent.
REQ-022 Rebased exp >= 2^EXP-1 SHALL produce infinity (exp all-ones, frac 0, sign kept) and set overflowSticky.
REQ-023 Rebased exp <= 0 SHALL produce zero (all fields 0, sign 0) and set underflowSticky.
REQ-024 Zero input SHALL yield all-zero logOut with no flag; infinity input SHALL yield infinity, sign kept, no flag.
REQ-025 Sticky flags SHALL set in the cycle the offending result enters S2 and hold until reset.

Reset
REQ-026 With reset high at a clock edge: S1/S2 valid SHALL clear (logOutValid=0), pipeline data and logOut SHALL be 0, both sticky flags SHALL be 0; in-flight results SHALL be discarded; accInReady SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-027 Macro PAPER_FLOAT_TO_LOG_RNE_EN: defined -> fraction reduction rounds to nearest, ties to even, on the dropped ACC_FRAC-FRAC bits; undefined -> truncation (dropped bits discarded, no carry). With FRAC==ACC_FRAC both modes SHALL be identical.

Verification (EXP=5, FRAC=4, ACC_EXP=8, ACC_FRAC=7)
REQ-028 accIn=0x3F80 (1.0), ready high -> logOut=0x0F0 exactly 2 cycles later, no flags.
REQ-029 accIn=0x3F8C (tie) -> 0x0F2 with macro, 0x0F1 without; accIn=0x3FFF -> 0x100 with macro (carry), 0x0FF without.
REQ-030 accIn=0x4780 -> 0x1F0, overflowSticky=1 and stays 1 over 10 further normal inputs; accIn=0x3800 -> 0x000, underflowSticky=1.
REQ-031 Stream 6 distinct values with logOutReady low 5 cycles -> accInReady low after 2 accepted; all 6 emerge in order once released, logOut stable while stalled.
REQ-032 Reset asserted with both stages full and flags set -> next cycle logOutValid=0, logOut=0, flags 0; item fed after reset returns 2 cycles later.
